// File: rtl/systolic_array_line_feeder.sv
// Line feeder for the 3x3 Scharr kernel cells: buffers two rows and
// presents rows r-2, r-1 and r as vertically aligned pixel triples.
module systolic_array_line_feeder #(
  parameter int data_width = 8,
  parameter int img_width  = 16,
  parameter int img_height = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_msg,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic [data_width-1:0] x1,
  output logic                  x1_val,
  output logic [data_width-1:0] x2,
  output logic                  x2_val,
  output logic [data_width-1:0] x3,
  output logic                  x3_val,
  output logic                  new_row,
  output logic                  frame_done
);

  localparam int CW = $clog2(img_width);
  localparam int RW = $clog2(img_height);
  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_EOL,
    S_EOF
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          acc;
  logic          row_ge2;
  logic          col_last;
  logic          row_last;
  logic          emit;

  logic [data_width-1:0] buf0 [img_width];
  logic [data_width-1:0] buf1 [img_width];

  assign acc      = in_val && in_rdy;
  assign row_ge2  = row_cnt >= RW'(2);
  assign col_last = col_cnt == COL_LAST;
  assign row_last = row_cnt == ROW_LAST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_n;
  end

  // in_rdy is gated by reset so it reads 0 while reset is held
  always_comb begin
    state_n    = state;
    in_rdy     = 1'b0;
    new_row    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_RUN: begin
        in_rdy = reset;
        if (acc && col_last) state_n = S_EOL;
      end
      S_EOL: begin
        new_row = row_ge2;
        state_n = row_last ? S_EOF : S_RUN;
      end
      S_EOF: begin
        frame_done = 1'b1;
        state_n    = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (acc) col_cnt <= col_last ? '0 : col_cnt + CW'(1);
      if (state == S_EOL && !row_last) row_cnt <= row_cnt + RW'(1);
      if (state == S_EOF) row_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1   <= '0;
      x2   <= '0;
      x3   <= '0;
      emit <= 1'b0;
    end else begin
      emit <= acc && row_ge2;
      if (acc) begin
        x1 <= buf1[col_cnt];
        x2 <= buf0[col_cnt];
        x3 <= in_msg;
      end
    end
  end

  // rows 0 and 1 refill both buffers before any triple is emitted
  always_ff @(posedge clk) begin
    if (acc) begin
      buf1[col_cnt] <= buf0[col_cnt];
      buf0[col_cnt] <= in_msg;
    end
  end

  assign x1_val = emit;
  assign x2_val = emit;
  assign x3_val = emit;

endmodule

// File: doc/systolic_array_line_feeder.md
# systolic_array_line_feeder

Streaming source for the 3×3 Scharr kernel cells. It accepts a raster-order pixel stream over a val/rdy handshake and keeps the previous two image rows in internal line buffers. For each column it drives three vertically aligned pixels (x1 = row r-2, x2 = row r-1, x3 = row r) with valids and a `new_row` marker into a kernel cell's x1/x2/x3 inputs. It sits between the frame input and the X/Y kernel cells. Kernel cells have no backpressure, so this block paces itself only through `in_rdy`.

## Interface
- data_width, 8, pixel width in bits
- img_width, 16, pixels per row (≥2)
- img_height, 16, rows per frame (≥3)

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- in_msg  input  data_width  incoming pixel, raster order
- in_val  input  1  in_msg valid
- in_rdy  output  1  block can accept a pixel this cycle
- x1  output  data_width  pixel at (r-2, c)
- x1_val  output  1  x1 valid
- x2  output  data_width  pixel at (r-1, c)
- x2_val  output  1  x2 valid
- x3  output  data_width  pixel at (r, c)
- x3_val  output  1  x3 valid
- new_row  output  1  last column of an emitted row is on x1..x3 this cycle
- frame_done  output  1  one-cycle pulse after the last row of a frame

## Operation
- Storage: two line buffers, buf0 (row r-1) and buf1 (row r-2), each img_width entries.
- Counters:
  - col_cnt: $clog2(img_width) bits, 0..img_width-1.
  - row_cnt: $clog2(img_height) bits, 0..img_height-1.
- Accept = in_val && in_rdy. On accept at column c:
  - buf1[c] ← buf0[c]; buf0[c] ← in_msg.
  - x1 ← old buf1[c], x2 ← old buf0[c], x3 ← in_msg.
  - col_cnt increments.
- Emission: x*_val ← 1 on accept only when row_cnt ≥ 2; otherwise 0. x1_val, x2_val and x3_val are always equal.
- x1..x3 hold their last value when not updated. Only the valids drop.
- FSM states:
  - RUN: in_rdy = 1. An accept with col_cnt = img_width-1 → EOL; col_cnt ← 0.
  - EOL: in_rdy = 0, one cycle. new_row = 1 iff row_cnt ≥ 2.
    - If row_cnt = img_height-1 → EOF.
    - Otherwise row_cnt++ → RUN.
  - EOF: in_rdy = 0, frame_done = 1, one cycle. row_cnt ← 0 → RUN.
- Line buffer contents are not reset or cleared between frames. Rows 0 and 1 overwrite them before any emission.
- Output widths equal data_width. No arithmetic on pixel data.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Outputs: in_rdy = 0 while asserted; x1, x2, x3, all valids, new_row, frame_done = 0.
  - State: FSM = RUN, col_cnt = row_cnt = 0.
  - First cycle after release: in_rdy = 1.
- Latency: outputs are registered and valid the cycle after the accepting edge. Each accepted pixel at row ≥ 2 produces exactly one valid cycle.
- Per-row bubble: exactly one cycle of in_rdy = 0 after each row, plus one more after the final row.
  - Frame throughput: img_width·img_height + img_height + 1 cycles at full input rate.
- new_row coincides with the cycle in which the last column's x*_val = 1.
- frame_done asserts the cycle after the final row's new_row. x*_val = 0 during frame_done.
- in_val low mid-row: no state change and no valid. The column index is preserved across stalls of any length.
- in_val high while in_rdy = 0: the pixel is not consumed. The source must hold it.
- Reset mid-frame: the partial frame is abandoned. The next pixel accepted is treated as row 0, col 0.

## Test plan
- Params 8/4/4, p(r,c) = 16r+c, in_val held 1. Rows 0–1: x*_val = 0 throughout; in_rdy = 0 exactly one cycle after col 3 of each row; new_row = 0.
- Row 2: outputs (x1,x2,x3) = (00,10,20), (01,11,21), (02,12,22), (03,13,23) on consecutive cycles. new_row = 1 and in_rdy = 0 with (03,13,23).
- Row 3: outputs (10,20,30) … (13,23,33) with new_row. frame_done = 1 the next cycle. in_rdy low for exactly 2 cycles. Total frame = 21 cycles.
- Random in_val gaps (e.g. 3 idle cycles inside row 2): the emitted sequence is unchanged, each value appears once, and there are no spurious valids during gaps.
- Back-to-back second frame, p(r,c) = 0x80+16r+c: no valids during its rows 0–1. The first output is (80,90,A0), with no stale data from frame 1.
- Assert reset while row 2 col 1 is on the outputs: outputs go to 0 immediately without waiting for a clock edge. After release, in_rdy = 1, and a fresh frame reproduces scenario 2 exactly.
